// File: rtl/axi_pkg.sv
// Shared AXI encodings and write-slave state type.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_SLVERR = 2'd2
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic is_wrap_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_write_slave_if.sv
// AXI4 write channels (AW, W, B) bundled for the write slave.
// Handshake rule for every channel: a transfer happens on a rising clock
// edge where VALID and READY are both high; a source holding VALID keeps its
// payload stable until that edge, and VALID never depends on READY.
interface axi_write_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  // Extra headroom so the wrap container ((len+1) << size) never overflows.
  localparam int CW = ADDR_WIDTH + 16;

  logic [CW-1:0] addr_x;
  logic [CW-1:0] size_bytes;
  logic [CW-1:0] aligned;
  logic [CW-1:0] incr;
  logic [CW-1:0] wrap_mask;
  logic [CW-1:0] wrap_addr;

  // Align down to the beat size, step one beat, then fold into the container for WRAP.
  always_comb begin
    addr_x     = CW'(addr);
    size_bytes = CW'(1) << size;
    aligned    = addr_x & ~(size_bytes - CW'(1));
    incr       = aligned + size_bytes;
    wrap_mask  = ((CW'(len) + CW'(1)) << size) - CW'(1);
    wrap_addr  = (addr_x & ~wrap_mask) | (incr & wrap_mask);
    next_addr  = addr;
    case (burst)
      BURST_INCR: next_addr = incr[ADDR_WIDTH-1:0];
      BURST_WRAP: next_addr = wrap_addr[ADDR_WIDTH-1:0];
      default:    next_addr = addr;
    endcase
  end
endmodule

// File: rtl/axi_write_slave.sv
// AXI4 write slave: one burst at a time, each beat becomes a single-cycle
// write on a word-addressed backend memory port, one B response per burst.
module axi_write_slave
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int OFF_BITS   = $clog2(STRB_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axi_write_slave_if.slave               bus,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-OFF_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  output logic [STRB_WIDTH-1:0]          mem_wstrb,
  output state_t                         state_dbg
);

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  burst_t                burst_q;
  logic [8:0]            cnt_q;
  logic                  req_err_q;
  logic                  last_err_q;

  logic aw_hs;
  logic w_hs;
  logic last_beat;
  logic aw_err;

  assign aw_hs     = (state_q == ST_IDLE) && bus.AWVALID;
  assign w_hs      = (state_q == ST_DATA) && bus.WVALID;
  assign last_beat = (cnt_q == {1'b0, len_q});

  // A request is refused (but still drained) for reserved bursts, oversize beats or illegal wrap lengths.
  always_comb begin
    aw_err = (bus.AWBURST == BURST_RSVD) ||
             (int'(bus.AWSIZE) > OFF_BITS) ||
             ((bus.AWBURST == BURST_WRAP) && !is_wrap_len(bus.AWLEN));
  end

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and channel ready/valid decode.
  always_comb begin
    state_d     = state_q;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.AWREADY = 1'b1;
        if (bus.AWVALID) state_d = ST_DATA;
      end
      ST_DATA: begin
        bus.WREADY = 1'b1;
        if (bus.WVALID && last_beat) state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.BVALID = 1'b1;
        if (bus.BREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst context: capture on AW, advance count/address and track WLAST misuse on W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= BURST_FIXED;
      cnt_q      <= '0;
      req_err_q  <= 1'b0;
      last_err_q <= 1'b0;
    end else if (aw_hs) begin
      id_q       <= bus.AWID;
      addr_q     <= bus.AWADDR;
      len_q      <= bus.AWLEN;
      size_q     <= bus.AWSIZE;
      burst_q    <= burst_t'(bus.AWBURST);
      cnt_q      <= '0;
      req_err_q  <= aw_err;
      last_err_q <= 1'b0;
    end else if (w_hs) begin
      cnt_q  <= cnt_q + 9'd1;
      addr_q <= next_addr;
      if (bus.WLAST != last_beat) last_err_q <= 1'b1;
    end
  end

  // Response and backend outputs; BID/BRESP only change outside RESP.
  always_comb begin
    bus.BID   = id_q;
    bus.BRESP = ((state_q == ST_RESP) && (req_err_q || last_err_q)) ? RESP_SLVERR : RESP_OKAY;
    mem_we    = w_hs && !req_err_q;
    mem_addr  = addr_q[ADDR_WIDTH-1:OFF_BITS];
    mem_wdata = bus.WDATA;
    mem_wstrb = bus.WSTRB;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_axi_write_slave.sv
// Randomized scoreboard bench for axi_write_slave (32-bit data, 12-bit address).
module tb_axi_write_slave;
  import axi_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  state_t      state_dbg;

  int checks_total;
  int checks_passed;

  logic [45:0] exp_q[$];    // {word addr, data, strb}
  logic [5:0]  exp_b_q[$];  // {id, resp}

  axi_write_slave_if #(.ID_WIDTH(4), .ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  axi_write_slave #(.ID_WIDTH(4), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_awready"}, 64'(bus.AWREADY), 64'd1);
    check({tag, "_wready"},  64'(bus.WREADY),  64'd0);
    check({tag, "_bvalid"},  64'(bus.BVALID),  64'd0);
    check({tag, "_bid"},     64'(bus.BID),     64'd0);
    check({tag, "_bresp"},   64'(bus.BRESP),   64'd0);
    check({tag, "_mem_we"},  64'(mem_we),      64'd0);
    check({tag, "_state"},   64'(state_dbg),   64'(ST_IDLE));
  endtask

  // ---------------- reference model ----------------
  function automatic logic req_error(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'd3) || (size > 3'd2) ||
           ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // Byte address of beat i, straight from the AXI burst definition.
  function automatic logic [11:0] beat_addr(input logic [11:0] start, input int i,
                                            input logic [2:0] size, input logic [7:0] len,
                                            input logic [1:0] burst);
    int bytes, s, aligned, total, base, a;
    bytes   = 1 << size;
    s       = int'(start);
    aligned = (s / bytes) * bytes;
    total   = (int'(len) + 1) * bytes;
    base    = (s / total) * total;
    if (burst == 2'd0 || i == 0) a = s;
    else if (burst == 2'd2)      a = base + ((aligned - base) + i * bytes) % total;
    else                         a = aligned + i * bytes;
    return 12'(a);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (exp_q.size() == 0) check("mem_we_unexpected", 64'd1, 64'd0);
        else check("mem_write", 64'({mem_addr, mem_wdata, mem_wstrb}), 64'(exp_q.pop_front()));
      end
      if (bus.BVALID && bus.BREADY) begin
        if (exp_b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
        else check("b_resp", 64'({bus.BID, bus.BRESP}), 64'(exp_b_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_burst(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int bad_last, input int bdelay, input int abort_after);
    logic        rerr;
    logic        any_err;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [5:0]  bexp;
    int          n;
    int          gap;
    rerr    = req_error(len, size, burst);
    any_err = rerr;

    bus.AWID    = id;
    bus.AWADDR  = addr;
    bus.AWLEN   = len;
    bus.AWSIZE  = size;
    bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    n = 0;
    while (!bus.AWREADY && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("aw_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.AWADDR  = 12'($urandom);
    check("wready_after_aw", 64'(bus.WREADY), 64'd1);
    check("awready_in_data", 64'(bus.AWREADY), 64'd0);

    for (int i = 0; i <= int'(len); i++) begin
      if (i == abort_after) begin
        rst_n = 1'b0;
        bus.WVALID = 1'b0;
        #2;
        check_reset_values("abort_in_reset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("abort_after_reset");
        return;
      end
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      bus.WDATA  = data;
      bus.WSTRB  = strb;
      bus.WLAST  = (i == int'(len));
      if (i == bad_last) begin
        bus.WLAST = !bus.WLAST;
        any_err   = 1'b1;
      end
      bus.WVALID = 1'b1;
      if (!rerr) exp_q.push_back({beat_addr(addr, i, size, len, burst) >> 2, data, strb});
      n = 0;
      while (!bus.WREADY && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 50) check("w_accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.WVALID = 1'b0;
    end

    check("bvalid_after_last", 64'(bus.BVALID), 64'd1);
    check("wready_after_last", 64'(bus.WREADY), 64'd0);
    bexp = {id, any_err ? 2'd2 : 2'd0};
    exp_b_q.push_back(bexp);
    for (int k = 0; k < bdelay; k++) begin
      @(negedge clk);
      check("b_hold_stable", 64'({bus.BVALID, bus.BID, bus.BRESP, bus.AWREADY}), 64'({1'b1, bexp, 1'b0}));
      @(posedge clk); #1;
    end
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    check("awready_after_b", 64'({bus.AWREADY, bus.BVALID}), 64'({1'b1, 1'b0}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          bad;
    checks_total  = 0;
    checks_passed = 0;
    rst_n       = 1'b0;
    bus.AWID    = '0;
    bus.AWADDR  = '0;
    bus.AWLEN   = '0;
    bus.AWSIZE  = '0;
    bus.AWBURST = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WLAST   = 1'b0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post_reset");

    run_burst(4'h5, 12'h100, 8'd3,  3'd2, 2'd1, -1, 1, -1);  // INCR 0x40..0x43
    run_burst(4'h6, 12'h108, 8'd3,  3'd2, 2'd2, -1, 0, -1);  // WRAP 0x42,0x43,0x40,0x41
    run_burst(4'h7, 12'h020, 8'd2,  3'd2, 2'd0, -1, 2, -1);  // FIXED 0x08 x3
    run_burst(4'h8, 12'h003, 8'd2,  3'd2, 2'd1, -1, 0, -1);  // unaligned INCR
    run_burst(4'h9, 12'h040, 8'd3,  3'd2, 2'd3, -1, 1, -1);  // reserved burst
    run_burst(4'hA, 12'h040, 8'd1,  3'd3, 2'd1, -1, 0, -1);  // oversize beat
    run_burst(4'hB, 12'h080, 8'd2,  3'd2, 2'd2, -1, 0, -1);  // illegal wrap length
    run_burst(4'hC, 12'h200, 8'd3,  3'd2, 2'd1,  1, 5, -1);  // early WLAST, BREADY held low
    run_burst(4'hD, 12'h300, 8'd3,  3'd2, 2'd1,  3, 0, -1);  // missing WLAST on final beat
    run_burst(4'hE, 12'hFF8, 8'd3,  3'd2, 2'd1, -1, 0, -1);  // address overflow wraps
    run_burst(4'h1, 12'h400, 8'd7,  3'd2, 2'd1, -1, 0,  2);  // reset after beat 2 of 8
    run_burst(4'h2, 12'h400, 8'd7,  3'd2, 2'd1, -1, 0, -1);  // clean burst after abort
    run_burst(4'h3, 12'h080, 8'd255, 3'd0, 2'd1, -1, 0, -1); // 256-beat burst
    run_burst(4'h4, 12'h013, 8'd15, 3'd0, 2'd2, -1, 1, -1);  // byte WRAP over 16

    for (int t = 0; t < 40; t++) begin
      burst = 2'($urandom_range(0, 3));
      size  = 3'($urandom_range(0, 3));
      if (burst == 2'd2 && $urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 3))
          0: len = 8'd1;
          1: len = 8'd3;
          2: len = 8'd7;
          default: len = 8'd15;
        endcase
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      run_burst(4'($urandom), 12'($urandom), len, size, burst, bad,
                int'($urandom_range(0, 3)), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("mem_queue_drained", 64'(exp_q.size()), 64'd0);
    check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
